// File: rtl/cpumc_arbiter_if.sv
// CPU memory-controller bus bundle: three masters in, muxed bus out.
// The arbiter takes the slave side; the requesting masters take master.
interface cpumc_arbiter_if;
  logic [15:0] cpu_a_in;
  logic        cpu_r_nw_in;
  logic [7:0]  cpu_d_in;
  logic        cpu_rdy_out;
  logic        hci_req_in;
  logic        hci_gnt_out;
  logic [15:0] hci_a_in;
  logic        hci_r_nw_in;
  logic [7:0]  hci_d_in;
  logic        dma_req_in;
  logic        dma_gnt_out;
  logic [15:0] dma_a_in;
  logic        dma_r_nw_in;
  logic [7:0]  dma_d_in;
  logic        dma_abort_out;
  logic [15:0] mc_a_out;
  logic        mc_r_nw_out;
  logic [7:0]  mc_d_out;
  logic [1:0]  owner_out;

  modport slave (
    input  cpu_a_in, cpu_r_nw_in, cpu_d_in,
    input  hci_req_in, hci_a_in, hci_r_nw_in, hci_d_in,
    input  dma_req_in, dma_a_in, dma_r_nw_in, dma_d_in,
    output cpu_rdy_out, hci_gnt_out, dma_gnt_out,
    output dma_abort_out, owner_out,
    output mc_a_out, mc_r_nw_out, mc_d_out
  );

  modport master (
    output cpu_a_in, cpu_r_nw_in, cpu_d_in,
    output hci_req_in, hci_a_in, hci_r_nw_in, hci_d_in,
    output dma_req_in, dma_a_in, dma_r_nw_in, dma_d_in,
    input  cpu_rdy_out, hci_gnt_out, dma_gnt_out,
    input  dma_abort_out, owner_out,
    input  mc_a_out, mc_r_nw_out, mc_d_out
  );
endinterface

// File: rtl/cpumc_arbiter.sv
// CPU memory-controller bus arbiter: CPU default owner, HCI highest
// priority, DMA with bounded tenure, stall/drain/gap handoff.
module cpumc_arbiter #(
  parameter int DRAIN_CYCLES   = 1,
  parameter int MAX_DMA_CYCLES = 514
) (
  input  logic           clk_in,
  input  logic           nrst_in,
  cpumc_arbiter_if.slave bus
);
  typedef enum logic [2:0] {
    S_CPU,
    S_STALL,
    S_DRAIN,
    S_HCI,
    S_DMA,
    S_GAP,
    S_RET
  } state_t;

  state_t      r_state;
  state_t      w_nxt;
  logic [2:0]  r_dcnt;
  logic [9:0]  r_tcnt;
  logic        r_rdy;
  logic        r_hgnt;
  logic        r_dgnt;
  logic        r_abort;
  logic [1:0]  r_owner;

  logic        w_hreq;
  logic        w_dreq;
  logic        w_drain_done;
  logic        w_timeout;
  logic        w_abort;
  logic [1:0]  w_owner;

  assign w_hreq       = bus.hci_req_in;
  assign w_dreq       = bus.dma_req_in;
  assign w_drain_done = (r_dcnt == 3'(DRAIN_CYCLES - 1));
  assign w_timeout    = (r_tcnt == 10'(MAX_DMA_CYCLES - 1));

  always_comb begin
    w_nxt   = r_state;
    w_abort = 1'b0;
    unique case (r_state)
      S_CPU: begin
        if (w_hreq || w_dreq) w_nxt = S_STALL;
      end
      S_STALL: w_nxt = S_DRAIN;
      S_DRAIN: begin
        if (w_drain_done) begin
          if (w_hreq)      w_nxt = S_HCI;
          else if (w_dreq) w_nxt = S_DMA;
          else             w_nxt = S_RET;
        end
      end
      S_HCI: begin
        if (!w_hreq) w_nxt = S_GAP;
      end
      S_DMA: begin
        if (!w_dreq) begin
          w_nxt = S_GAP;
        end else if (w_timeout) begin
          w_nxt   = S_GAP;
          w_abort = 1'b1;
        end
      end
      // HCI-first here also keeps a timed-out DMA behind a waiting HCI
      S_GAP: begin
        if (w_hreq)      w_nxt = S_HCI;
        else if (w_dreq) w_nxt = S_DMA;
        else             w_nxt = S_RET;
      end
      S_RET:   w_nxt = S_CPU;
      default: w_nxt = S_CPU;
    endcase
  end

  always_comb begin
    w_owner = 2'b11;
    unique case (w_nxt)
      S_CPU:   w_owner = 2'b00;
      S_HCI:   w_owner = 2'b01;
      S_DMA:   w_owner = 2'b10;
      default: w_owner = 2'b11;
    endcase
  end

  always_ff @(posedge clk_in or negedge nrst_in) begin
    if (!nrst_in) begin
      r_state <= S_CPU;
      r_dcnt  <= '0;
      r_tcnt  <= '0;
      r_rdy   <= 1'b1;
      r_hgnt  <= 1'b0;
      r_dgnt  <= 1'b0;
      r_abort <= 1'b0;
      r_owner <= 2'b00;
    end else begin
      r_state <= w_nxt;
      r_dcnt  <= (r_state == S_DRAIN && w_nxt == S_DRAIN)
                 ? r_dcnt + 3'd1 : '0;
      r_tcnt  <= (r_state == S_DMA && w_nxt == S_DMA)
                 ? r_tcnt + 10'd1 : '0;
      r_rdy   <= (w_nxt == S_CPU);
      r_hgnt  <= (w_nxt == S_HCI);
      r_dgnt  <= (w_nxt == S_DMA);
      r_abort <= w_abort;
      r_owner <= w_owner;
    end
  end

  // Writes reach the bus only from the owning master
  always_comb begin
    bus.mc_a_out    = bus.cpu_a_in;
    bus.mc_r_nw_out = 1'b1;
    bus.mc_d_out    = 8'h00;
    unique case (r_state)
      S_CPU: begin
        bus.mc_r_nw_out = bus.cpu_r_nw_in;
        bus.mc_d_out    = bus.cpu_d_in;
      end
      S_STALL: bus.mc_d_out = bus.cpu_d_in;
      S_HCI: begin
        bus.mc_a_out    = bus.hci_a_in;
        bus.mc_r_nw_out = bus.hci_r_nw_in;
        bus.mc_d_out    = bus.hci_d_in;
      end
      S_DMA: begin
        bus.mc_a_out    = bus.dma_a_in;
        bus.mc_r_nw_out = bus.dma_r_nw_in;
        bus.mc_d_out    = bus.dma_d_in;
      end
      default: begin
        bus.mc_a_out    = bus.cpu_a_in;
        bus.mc_r_nw_out = 1'b1;
        bus.mc_d_out    = 8'h00;
      end
    endcase
  end

  assign bus.cpu_rdy_out   = r_rdy;
  assign bus.hci_gnt_out   = r_hgnt;
  assign bus.dma_gnt_out   = r_dgnt;
  assign bus.dma_abort_out = r_abort;
  assign bus.owner_out     = r_owner;
endmodule
